// File: rtl/note_tone_gen_pkg.sv
// Shared constants for the three-voice tone generator.
//   DefNumberOfBits : default half-period word / voice counter width
//   PwmSlots        : speaker PWM frame length in clock cycles
//   OutRange        : mute code from the keyboard input stage
package note_tone_gen_pkg;

  localparam int DefNumberOfBits = 20;
  localparam int PwmSlots        = 3;
  localparam int OutRange        = 0;

  typedef logic [1:0] level_t;

  // Slot sequence 0,1,..,PwmSlots-1,0,...
  function automatic level_t slot_next(input level_t slot);
    return (slot == level_t'(PwmSlots - 1)) ? '0 : level_t'(slot + 2'd1);
  endfunction

endpackage

// File: rtl/note_voice.sv
// One square-wave voice.
//   Clock, Reset : system clock, async active-high reset
//   Note         : half-period in cycles, OutRange (0) = mute
//   Tone         : registered 50 %-duty square wave, period 2*Note
module note_voice
  import note_tone_gen_pkg::*;
#(
  parameter int NumberOfBits = DefNumberOfBits
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NumberOfBits-1:0] Note,
  output logic                    Tone
);

  logic [NumberOfBits-1:0] cnt_q, cnt_d;
  logic [NumberOfBits-1:0] note_q;
  logic                    tone_q, tone_d;

  // Cnt counts 1..Note within each half-period, so it never exceeds Note
  // and cannot wrap. A changed Note restarts the phase on a rising edge.
  always_comb begin
    cnt_d  = cnt_q + NumberOfBits'(1);
    tone_d = tone_q;
    if (Note == NumberOfBits'(OutRange)) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (Note != note_q) begin
      cnt_d  = NumberOfBits'(1);
      tone_d = 1'b1;
    end else if (cnt_q == Note) begin
      cnt_d  = NumberOfBits'(1);
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      note_q <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      note_q <= Note;
      tone_q <= tone_d;
    end
  end

  assign Tone = tone_q;

endmodule

// File: rtl/note_tone_gen.sv
// Three-voice square-wave tone generator with 2-bit mixer and PWM speaker.
//   Clock, Reset         : 50 MHz clock, async active-high reset
//   NoteC/NoteD/NoteE    : half-period words in cycles, 0 = mute
//   ToneC/ToneD/ToneE    : per-voice square waves
//   Level                : count of tones high (lags tones by 1 cycle)
//   Speaker              : PWM of Level over a PwmSlots frame (lags Level by 1)
//   Active               : any Note nonzero (lags inputs by 1)
module note_tone_gen
  import note_tone_gen_pkg::*;
#(
  parameter int NumberOfBits = DefNumberOfBits
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NumberOfBits-1:0] NoteC,
  input  logic [NumberOfBits-1:0] NoteD,
  input  logic [NumberOfBits-1:0] NoteE,
  output logic                    ToneC,
  output logic                    ToneD,
  output logic                    ToneE,
  output logic [1:0]              Level,
  output logic                    Speaker,
  output logic                    Active
);

  localparam int NumVoices = 3;

  logic [NumVoices-1:0][NumberOfBits-1:0] note_w;
  logic [NumVoices-1:0]                   tone_w;

  assign note_w = {NoteE, NoteD, NoteC};

  for (genvar v = 0; v < NumVoices; v++) begin : g_voice
    note_voice #(.NumberOfBits(NumberOfBits)) u_voice (
      .Clock (Clock),
      .Reset (Reset),
      .Note  (note_w[v]),
      .Tone  (tone_w[v])
    );
  end

  level_t level_q, level_d;
  level_t slot_q;
  logic   speaker_q, active_q, active_d;

  // Zero-extended sum of three 1-bit tones fits in 2 bits.
  assign level_d  = level_t'(tone_w[0]) + level_t'(tone_w[1]) + level_t'(tone_w[2]);
  assign active_d = (NoteC != NumberOfBits'(OutRange)) |
                    (NoteD != NumberOfBits'(OutRange)) |
                    (NoteE != NumberOfBits'(OutRange));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level_q   <= '0;
      slot_q    <= '0;
      speaker_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      level_q   <= level_d;
      slot_q    <= slot_next(slot_q);
      speaker_q <= (slot_q < level_q);
      active_q  <= active_d;
    end
  end

  assign ToneC   = tone_w[0];
  assign ToneD   = tone_w[1];
  assign ToneE   = tone_w[2];
  assign Level   = level_q;
  assign Speaker = speaker_q;
  assign Active  = active_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: a phase-based reference builds the
// expected outputs per edge into a scoreboard queue, popped after the edge.
module tb_note_tone_gen;
  import note_tone_gen_pkg::*;

  localparam int NB = 20;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [NB-1:0] NoteC, NoteD, NoteE;
  logic          ToneC, ToneD, ToneE, Speaker, Active;
  logic [1:0]    Level;

  note_tone_gen #(.NumberOfBits(NB)) dut (
    .Clock(Clock), .Reset(Reset),
    .NoteC(NoteC), .NoteD(NoteD), .NoteE(NoteE),
    .ToneC(ToneC), .ToneD(ToneD), .ToneE(ToneE),
    .Level(Level), .Speaker(Speaker), .Active(Active)
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic       tc, td, te;
    logic [1:0] lvl;
    logic       spk, act;
  } obs_t;

  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: each voice's tone is a function of cycles since its
  // last phase restart; mixer/PWM stages lag by one edge each.
  int      edge_n;
  int      m_prev[3];
  int      m_rst[3];
  logic    m_t[3];
  logic [1:0] m_lvl, m_slot;

  function automatic obs_t sample();
    return {ToneC, ToneD, ToneE, Level, Speaker, Active};
  endfunction

  task automatic model_reset();
    edge_n = 0;
    m_lvl  = 2'd0;
    m_slot = 2'd0;
    for (int v = 0; v < 3; v++) begin
      m_prev[v] = 0; m_rst[v] = 0; m_t[v] = 1'b0;
    end
  endtask

  // Push expectation for the coming edge, clock it, return observed.
  task automatic advance(output obs_t act);
    int   n[3];
    logic nt[3];
    obs_t e;
    n[0] = int'(NoteC); n[1] = int'(NoteD); n[2] = int'(NoteE);
    edge_n++;
    for (int v = 0; v < 3; v++) begin
      if (n[v] == 0) nt[v] = 1'b0;
      else begin
        if (n[v] != m_prev[v]) m_rst[v] = edge_n;
        nt[v] = (((edge_n - m_rst[v]) / n[v]) % 2) == 0;
      end
      m_prev[v] = n[v];
    end
    e.tc  = nt[0]; e.td = nt[1]; e.te = nt[2];
    e.lvl = 2'(m_t[0]) + 2'(m_t[1]) + 2'(m_t[2]);
    e.spk = (m_slot < m_lvl);
    e.act = (n[0] != 0) || (n[1] != 0) || (n[2] != 0);
    for (int v = 0; v < 3; v++) m_t[v] = nt[v];
    m_lvl  = e.lvl;
    m_slot = (m_slot == 2'd2) ? 2'd0 : m_slot + 2'd1;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    act = sample();
  endtask

  task automatic test_reset();
    obs_t act, exp;
    NoteC = '0; NoteD = '0; NoteE = '0;
    Reset = 1'b1;
    #25;
    sb.push_back('0);
    act = sample(); exp = sb.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL reset_async got %b want %b", act, exp);
    end
    @(posedge Clock); #1;
    sb.push_back('0);
    act = sample(); exp = sb.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL reset_held got %b want %b", act, exp);
    end
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic run_cycles(input string name, input int cycles);
    obs_t act, exp;
    for (int i = 0; i < cycles; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s cyc%0d got %b want %b", name, i, act, exp);
      end
    end
  endtask

  task automatic test_tone4();
    obs_t act, exp;
    NoteC = 20'd4;
    for (int i = 0; i < 20; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL tone4 cyc%0d got %b want %b", i, act, exp);
      end
    end
    NoteC = '0;
    run_cycles("tone4_off", 4);
  endtask

  task automatic test_note1();
    obs_t act, exp;
    NoteC = 20'd1;
    for (int i = 0; i < 8; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL note1 cyc%0d got %b want %b", i, act, exp);
      end
    end
    NoteC = '0;
    run_cycles("note1_off", 3);
  endtask

  task automatic test_phase_restart();
    obs_t act, exp;
    NoteC = 20'd6;
    run_cycles("restart_pre", 3);
    NoteC = 20'd3;
    for (int i = 0; i < 12; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL restart cyc%0d got %b want %b", i, act, exp);
      end
    end
    NoteC = '0;
    run_cycles("restart_off", 3);
  endtask

  task automatic test_all_same();
    obs_t act, exp;
    NoteC = 20'd5; NoteD = 20'd5; NoteE = 20'd5;
    for (int i = 0; i < 22; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL all5 cyc%0d got %b want %b", i, act, exp);
      end
    end
    NoteC = '0; NoteD = '0; NoteE = '0;
    run_cycles("all5_off", 4);
  endtask

  task automatic test_mute_mid();
    obs_t act, exp;
    NoteD = 20'd8;
    run_cycles("mute_pre", 5);
    NoteD = '0;
    for (int i = 0; i < 4; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL mute cyc%0d got %b want %b", i, act, exp);
      end
      vectors++;
      if (dut.g_voice[1].u_voice.cnt_q !== 20'd0) begin
        miscompares++;
        $display("FAIL mute_cnt cyc%0d got %0d want 0", i, dut.g_voice[1].u_voice.cnt_q);
      end
    end
  endtask

  task automatic test_reset_pulse();
    obs_t act, exp;
    NoteC = 20'd5; NoteD = 20'd5; NoteE = 20'd5;
    run_cycles("pulse_pre", 7);
    #3 Reset = 1'b1;
    #1;
    sb.push_back('0);
    act = sample(); exp = sb.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL pulse_async got %b want %b", act, exp);
    end
    NoteC = '0; NoteD = '0; NoteE = 20'd2;
    @(posedge Clock); #1;
    sb.push_back('0);
    act = sample(); exp = sb.pop_front(); vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL pulse_held got %b want %b", act, exp);
    end
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      advance(act);
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL pulse_after cyc%0d got %b want %b", i, act, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tone4();
    test_note1();
    test_phase_restart();
    test_all_same();
    test_mute_mid();
    test_reset_pulse();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Three-voice square-wave tone generator that sits directly downstream of the keyboard input stage. It consumes the three registered half-period words (NoteC, NoteD, NoteE, in 50 MHz clock cycles, 0 = silent) and turns each into a 50 %-duty square wave. It mixes the three voices into a 2-bit loudness level and drives a 1-bit PWM speaker pin.

## Interface
- NumberOfBits, default 20: width of each half-period input word and of each voice counter.
- Clock  input  1  system clock, 50 MHz.
- Reset  input  1  asynchronous, active-high; clears all state.
- NoteC  input  NumberOfBits  half-period of voice C in cycles; 0 = mute.
- NoteD  input  NumberOfBits  half-period of voice D; 0 = mute.
- NoteE  input  NumberOfBits  half-period of voice E; 0 = mute.
- ToneC  output  1  square wave of voice C.
- ToneD  output  1  square wave of voice D.
- ToneE  output  1  square wave of voice E.
- Level  output  2  number of tones currently high, range 0..3.
- Speaker  output  1  PWM of Level over a 3-cycle frame.
- Active  output  1  high when any Note input is nonzero.

## Operation
- Reset clock: Clock. Reset: Reset, asynchronous, active-high.
- Reset values: all Tone outputs, Level, Speaker and Active are 0. All counters, NoteQ registers and the slot counter are 0.
- Per voice state: Cnt[NumberOfBits-1:0], NoteQ[NumberOfBits-1:0] and Tone. Every edge, NoteQ <= Note. Then apply the first matching rule:
  - Note == 0: Cnt <= 0, Tone <= 0 (muted).
  - Note != NoteQ: Cnt <= 1, Tone <= 1. This is a phase restart and gives a rising edge.
  - Cnt == Note: Cnt <= 1, Tone <= ~Tone.
  - Otherwise: Cnt <= Cnt + 1.
- Result: Tone is high for exactly Note cycles, then low for Note cycles, giving a period of 2*Note. Note = 1 toggles every cycle.
- A change to the half-period while the voice is sounding restarts the phase immediately. There is no wait for the current half-period to finish.
- A note value held at 0 keeps the counter frozen at 0. The counter never wraps, because Cnt is always ≤ Note.
- Mixer: Level <= ToneC + ToneD + ToneE, computed as a zero-extended 2-bit sum (maximum 3, no overflow).
- PWM:
  - Slot is a 2-bit counter sequencing 0, 1, 2, 0, … free-running from reset.
  - Speaker <= (Slot < Level).
  - Level 0 gives constant 0; level 3 gives constant 1; levels 1 and 2 give 1/3 and 2/3 duty.
- Active <= (NoteC != 0) | (NoteD != 0) | (NoteE != 0).
- Simultaneous changes on all three voices are independent. Each voice obeys its own rules in the same cycle.

## Timing
- Note at edge n differs from NoteQ: Tone = 1 after edge n, and the first toggle follows edge n+Note.
- Note goes to 0, sampled at edge n: Tone = 0 after edge n.
- Level follows the Tone registers with a lag of 1 edge.
- Speaker follows Level with a lag of 1 edge, so the tone-to-speaker latency is 2 cycles.
- Active follows the Note inputs with a lag of 1 edge.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
  - After release, Slot restarts at 0.
  - Any nonzero Note is treated as a change, because NoteQ = 0. The voice therefore restarts with Tone = 1 on the first edge.
- Performance: no combinational path from input to output. At 50 MHz, the timing-critical path is the NumberOfBits-wide equality compare plus increment.

## Structure
- The shared package holds:
  - NumberOfBits default (20).
  - PWM frame length constant PwmSlots = 3.
  - Mute code constant OutRange = 0, shared with the input stage.
- Sub-module note_voice holds Cnt, NoteQ and Tone. It has ports Clock, Reset, Note, Tone and is instantiated three times.
- The top level contains the voice instances, the mixer adder, the Slot counter, the Speaker compare and the Active OR.

## Test plan
- Reset, then NoteC = 4, others 0: ToneC = 1 for 4 cycles, then 0 for 4 cycles, repeating. Level alternates 1/0 one cycle later. Speaker pattern is 1,0,0 per frame while Level = 1. Active = 1.
- NoteC = 1: ToneC toggles every cycle (period 2 cycles).
- NoteC changes 6 → 3 mid-high-phase: ToneC = 1 on the next edge, then follows 3 high / 3 low with the phase restarted.
- NoteC = NoteD = NoteE = 5 applied in the same cycle: all Tones identical. Level = 3 for 5 cycles, then 0 for 5 cycles. Speaker is constant 1 then constant 0, lagging the tones by 2 cycles.
- NoteD = 8, then set to 0 mid-period: ToneD = 0 after the next edge, Cnt holds 0. Active drops one cycle later if the other voices are silent.
- Reset pulse while all voices are sounding: all outputs 0 immediately. After release with NoteE = 2, ToneE restarts high on the first edge, and Slot restarts at 0.
